pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program counter with an integrated hardware return-address stack, used by the CPU execution unit to sequence instruction fetch. It adds PC-relative branch, subroutine call and return to the basic load/increment behaviour, with a configurable address width, stack depth and reset vector. Q drives the instruction memory address; stack status and error flags go to the control unit.

## Interface
- WIDTH, 16, address width in bits (≥ 4)
- DEPTH, 8, return-stack entries (power of two, ≥ 2)
- RESET_ADDR, 0, value loaded into Q on reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- ld  input  1  absolute load: Q ← D
- inc  input  1  increment: Q ← Q + 1
- br  input  1  relative branch: Q ← Q + off
- call  input  1  subroutine call: push Q + 1, Q ← D
- ret  input  1  return: Q ← popped entry
- clr_err  input  1  clears stk_err
- D  input  WIDTH  absolute target for ld/call
- off  input  WIDTH  two's-complement branch offset
- Q  output  WIDTH  current program counter
- top  output  WIDTH  current top-of-stack entry; 0 when empty
- depth_cnt  output  log2(DEPTH)+1  number of valid stack entries
- full  output  1  depth_cnt == DEPTH
- empty  output  1  depth_cnt == 0
- stk_err  output  1  sticky stack overflow/underflow flag

## Operation
- One command executes per cycle; fixed priority when several asserted: call > ret > ld > br > inc. Lower-priority requests that cycle are ignored, not queued.
- No command asserted: Q, stack and depth_cnt hold.
- inc: Q ← Q + 1, modulo 2^WIDTH (all-ones wraps to 0).
- br: Q ← Q + off, modulo 2^WIDTH; negative off gives backward branch.
- ld: Q ← D.
- call, not full: stack[depth_cnt] ← Q + 1 (mod 2^WIDTH), depth_cnt + 1, Q ← D.
- call, full: rejected; Q, stack, depth_cnt unchanged; stk_err ← 1.
- ret, not empty: Q ← stack[depth_cnt − 1], depth_cnt − 1.
- ret, empty: rejected; Q and depth_cnt unchanged; stk_err ← 1.
- stk_err: sets on any rejected call/ret; stays set until clr_err or reset. Same-cycle set and clr_err: set wins.
- top, full, empty: combinational from registered depth_cnt and stack contents.
- Stack storage need not be cleared by reset; only depth_cnt is. Entries at index ≥ depth_cnt never affect outputs.

## Timing
- All state updates on rising clk; results visible on Q/top/depth_cnt the cycle after the command is sampled.
- Latency: one cycle for every command; back-to-back commands each cycle supported (e.g. call followed by ret returns on the second edge).
- Reset (asynchronous, any time incl. mid-operation): Q = RESET_ADDR, depth_cnt = 0, empty = 1, full = 0, top = 0, stk_err = 0, immediately and held while reset is high. First command takes effect on the first rising edge after reset deasserts.
- Inputs must be stable around the rising edge; no combinational path from command inputs to any output.

## Test plan
- Reset/inc/wrap: WIDTH=16, RESET_ADDR=0x0100; reset → Q=0x0100, empty=1; ld D=0xFFFE then inc ×3 → Q=0xFFFF, 0x0000, 0x0001.
- Branch: Q=0x0040, br off=0x0010 → 0x0050; br off=0xFFF0 (−16) → 0x0040; br+inc same cycle → br wins, Q=0x0030 with off=0xFFF0.
- Nested call/ret: Q=0x0010; call D=0x0200 → Q=0x0200, top=0x0011, depth_cnt=1; call D=0x0300 → top=0x0201, depth_cnt=2; ret → Q=0x0201; ret → Q=0x0011, empty=1.
- Overflow: DEPTH=8, perform 8 calls → full=1; 9th call D=0x0AAA → Q and depth_cnt unchanged, stk_err=1; clr_err → stk_err=0.
- Underflow and priority: empty, ret → Q unchanged, stk_err=1; call+ret+ld same cycle → call executes only.
- Async reset mid-sequence: depth_cnt=3, Q=0x1234, reset pulsed between edges → Q=RESET_ADDR, depth_cnt=0, stk_err=0 before next edge; subsequent ret → underflow error.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack; every command resolves in one cycle.
// No backpressure: a rejected call (full) or ret (empty) holds all state and raises sticky stk_err.
module pc_stack_unit #(
    parameter int unsigned           WIDTH      = 16,
    parameter int unsigned           DEPTH      = 8,
    parameter logic [WIDTH-1:0]      RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld,
    input  logic                         inc,
    input  logic                         br,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         clr_err,
    input  logic [WIDTH-1:0]             D,
    input  logic [WIDTH-1:0]             off,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH):0]       depth_cnt,
    output logic                         full,
    output logic                         empty,
    output logic                         stk_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] PC_ONE    = WIDTH'(1);
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]      CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] q_nxt;
    logic [AW:0]      cnt_nxt;
    logic             push;
    logic             err_set;

    assign full     = (depth_cnt == CNT_DEPTH);
    assign empty    = (depth_cnt == '0);
    assign top_idx  = AW'(depth_cnt - CNT_ONE);
    assign wr_idx   = depth_cnt[AW-1:0];
    assign ret_addr = Q + PC_ONE;
    // Stale entries above depth_cnt are masked so storage needs no reset.
    assign top      = empty ? '0 : stack[top_idx];

    always_comb begin
        q_nxt   = Q;
        cnt_nxt = depth_cnt;
        push    = 1'b0;
        err_set = 1'b0;
        if (call) begin
            if (full) begin
                err_set = 1'b1;
            end else begin
                push    = 1'b1;
                cnt_nxt = depth_cnt + CNT_ONE;
                q_nxt   = D;
            end
        end else if (ret) begin
            if (empty) begin
                err_set = 1'b1;
            end else begin
                q_nxt   = top;
                cnt_nxt = depth_cnt - CNT_ONE;
            end
        end else if (ld) begin
            q_nxt = D;
        end else if (br) begin
            q_nxt = Q + off;
        end else if (inc) begin
            q_nxt = Q + PC_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q         <= RESET_ADDR;
            depth_cnt <= '0;
            stk_err   <= 1'b0;
        end else begin
            Q         <= q_nxt;
            depth_cnt <= cnt_nxt;
            stk_err   <= err_set | (stk_err & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack[wr_idx] <= ret_addr;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed-vector bench for pc_stack_unit (WIDTH=16, DEPTH=8, RESET_ADDR=0x0100).
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld, inc, br, call, ret, clr_err;
    logic [15:0] D, off;
    logic [15:0] Q, top;
    logic [3:0]  depth_cnt;
    logic        full, empty, stk_err;
    int          total = 0;
    int          bad   = 0;

    pc_stack_unit #(.WIDTH(16), .DEPTH(8), .RESET_ADDR(16'h0100)) dut (
        .clk(clk), .reset(reset), .ld(ld), .inc(inc), .br(br), .call(call),
        .ret(ret), .clr_err(clr_err), .D(D), .off(off), .Q(Q), .top(top),
        .depth_cnt(depth_cnt), .full(full), .empty(empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply the staged command across one rising edge, then drop all commands.
    task automatic tick();
        @(posedge clk);
        #1;
        ld = 0; inc = 0; br = 0; call = 0; ret = 0; clr_err = 0;
    endtask

    initial begin
        reset = 1; ld = 0; inc = 0; br = 0; call = 0; ret = 0; clr_err = 0;
        D = '0; off = '0;
        #3;
        chk("rst_q", Q, 16'h0100);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_top", top, 0);
        chk("rst_depth", depth_cnt, 0);
        chk("rst_err", stk_err, 0);
        @(negedge clk); reset = 0;

        ld = 1; D = 16'hFFFE; tick();
        chk("ld", Q, 16'hFFFE);
        inc = 1; tick(); chk("inc1", Q, 16'hFFFF);
        inc = 1; tick(); chk("inc_wrap", Q, 16'h0000);
        inc = 1; tick(); chk("inc3", Q, 16'h0001);
        tick(); chk("hold", Q, 16'h0001);

        ld = 1; D = 16'h0040; tick();
        br = 1; off = 16'h0010; tick(); chk("br_fwd", Q, 16'h0050);
        br = 1; off = 16'hFFF0; tick(); chk("br_back", Q, 16'h0040);
        br = 1; inc = 1; off = 16'hFFF0; tick(); chk("br_over_inc", Q, 16'h0030);

        ld = 1; D = 16'h0010; tick();
        call = 1; D = 16'h0200; tick();
        chk("call1_q", Q, 16'h0200);
        chk("call1_top", top, 16'h0011);
        chk("call1_depth", depth_cnt, 1);
        call = 1; D = 16'h0300; tick();
        chk("call2_q", Q, 16'h0300);
        chk("call2_top", top, 16'h0201);
        chk("call2_depth", depth_cnt, 2);
        ret = 1; tick();
        chk("ret1_q", Q, 16'h0201);
        chk("ret1_top", top, 16'h0011);
        ret = 1; tick();
        chk("ret2_q", Q, 16'h0011);
        chk("ret2_empty", empty, 1);
        chk("ret2_top", top, 0);

        // Eight calls from Q=0x0011: pushes 0x0012, 0x1001..0x1007.
        for (int i = 0; i < 8; i++) begin
            call = 1; D = 16'h1000 + 16'(i); tick();
        end
        chk("ovf_full", full, 1);
        chk("ovf_depth8", depth_cnt, 8);
        chk("ovf_top8", top, 16'h1007);
        call = 1; D = 16'h0AAA; tick();
        chk("ovf_q", Q, 16'h1007);
        chk("ovf_depth", depth_cnt, 8);
        chk("ovf_err", stk_err, 1);
        tick(); chk("err_sticky", stk_err, 1);
        clr_err = 1; tick(); chk("clr_err", stk_err, 0);
        call = 1; clr_err = 1; D = 16'h0AAA; tick(); chk("set_wins", stk_err, 1);
        clr_err = 1; tick();

        for (int k = 0; k < 8; k++) begin
            ret = 1; tick();
            chk($sformatf("pop%0d", k), Q, (k < 7) ? 32'h1007 - 32'(k) : 32'h0012);
        end
        chk("pop_empty", empty, 1);
        chk("pop_err", stk_err, 0);

        ret = 1; tick();
        chk("unf_q", Q, 16'h0012);
        chk("unf_err", stk_err, 1);
        chk("unf_depth", depth_cnt, 0);
        clr_err = 1; tick();

        call = 1; ret = 1; ld = 1; D = 16'h0500; tick();
        chk("prio_q", Q, 16'h0500);
        chk("prio_depth", depth_cnt, 1);
        chk("prio_top", top, 16'h0501 - 16'h04EE);

        call = 1; D = 16'h0600; tick();
        call = 1; D = 16'h1234; tick();
        chk("pre_rst_depth", depth_cnt, 3);
        chk("pre_rst_q", Q, 16'h1234);
        #1 reset = 1;
        #1;
        chk("arst_q", Q, 16'h0100);
        chk("arst_depth", depth_cnt, 0);
        chk("arst_empty", empty, 1);
        chk("arst_top", top, 0);
        chk("arst_err", stk_err, 0);
        reset = 0;
        ret = 1; tick();
        chk("post_rst_q", Q, 16'h0100);
        chk("post_rst_err", stk_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
